// File: rtl/fp_div_seq.sv
// Sequential minifloat divider q = a / b: restoring division, one quotient bit per cycle,
// round to nearest even, valid/ready handshakes on both sides.
module fp_div_seq #(
    parameter int NEXP      = 2,
    parameter int NSIG      = 5,
    parameter int NORMAL    = 0,
    parameter int SUBNORMAL = 1,
    parameter int ZERO      = 2,
    parameter int INFINITY  = 3,
    parameter int QNAN      = 4,
    parameter int SNAN      = 5,
    parameter int LAST_FLAG = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NEXP+NSIG:0]   a,
    input  logic [NEXP+NSIG:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NEXP+NSIG:0]   q,
    output logic [LAST_FLAG-1:0] qFlags,
    output logic [NEXP:0]        exp_overflow
);
    localparam int W     = NEXP + NSIG + 1;
    localparam int M     = NSIG + 1;
    localparam int RW    = NSIG + 2;
    localparam int QW    = NSIG + 3;
    localparam int EW    = NEXP + $clog2(NSIG + 1) + 3;
    localparam int CW    = $clog2(NSIG + 2);
    localparam int OVW   = NEXP + 1;
    localparam int BIAS  = 2 ** (NEXP - 1) - 1;
    localparam int EMAX  = 2 ** NEXP - 2;
    localparam int OVMAX = 2 ** OVW - 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] NORM  = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] ROUND = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [W-1:0]         a_q, a_d, b_q, b_d;
    logic [M-1:0]         mb_q, mb_d;
    logic [RW-1:0]        rem_q, rem_d;
    logic [QW-1:0]        quo_q, quo_d;
    logic signed [EW-1:0] e_q, e_d;
    logic                 sign_q, sign_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [W-1:0]         q_q, q_d;
    logic [LAST_FLAG-1:0] flags_q, flags_d;
    logic [OVW-1:0]       ovf_q, ovf_d;

    function automatic logic [EW+M-1:0] normalize(input logic [NEXP-1:0] e, input logic [NSIG-1:0] f);
        logic [M-1:0]  m;
        logic [EW-1:0] x;
        m = {(e != '0), f};
        x = (e != '0) ? EW'(e) : EW'(1);
        for (int unsigned i = 0; i < NSIG; i++) begin
            if (!m[M-1] && m != '0) begin
                m = m << 1;
                x = x - EW'(1);
            end
        end
        return {x, m};
    endfunction

    // Operand decode and classification, valid while in NORM
    logic [EW+M-1:0]      na, nb;
    logic [M-1:0]         ma, mb;
    logic signed [EW-1:0] xa, xb, e_norm;
    logic                 za, zb, ia, ib, nan_a, nan_b;
    logic                 s_res;
    logic                 ge0;
    logic [M-1:0]         rem0;

    always_comb begin
        na     = normalize(a_q[W-2:NSIG], a_q[NSIG-1:0]);
        nb     = normalize(b_q[W-2:NSIG], b_q[NSIG-1:0]);
        ma     = na[M-1:0];
        mb     = nb[M-1:0];
        xa     = na[EW+M-1:M];
        xb     = nb[EW+M-1:M];
        e_norm = xa - xb + EW'(BIAS);
        za     = (a_q[W-2:0] == '0);
        zb     = (b_q[W-2:0] == '0);
        ia     = (a_q[W-2:NSIG] == '1) && (a_q[NSIG-1:0] == '0);
        ib     = (b_q[W-2:NSIG] == '1) && (b_q[NSIG-1:0] == '0);
        nan_a  = (a_q[W-2:NSIG] == '1) && (a_q[NSIG-1:0] != '0);
        nan_b  = (b_q[W-2:NSIG] == '1) && (b_q[NSIG-1:0] != '0);
        s_res  = a_q[W-1] ^ b_q[W-1];
        ge0    = (ma >= mb);
        rem0   = ge0 ? ma - mb : ma;
    end

    // Rounding: quotient alignment, subnormal denormalisation, RNE and overflow saturation
    logic [M-1:0]         sig;
    logic [M:0]           wv, sum;
    logic                 stk, inc;
    logic signed [EW-1:0] er, ef, excess;
    int                   shamt;
    logic [NSIG-1:0]      frac;
    logic [W-1:0]         rq;
    logic [LAST_FLAG-1:0] rflags;
    logic [OVW-1:0]       rovf;

    always_comb begin
        sig    = quo_q[QW-1] ? quo_q[QW-1:2] : quo_q[QW-2:1];
        wv     = {sig, (quo_q[QW-1] ? quo_q[1] : quo_q[0])};
        stk    = (rem_q != '0) | (quo_q[QW-1] & quo_q[0]);
        er     = quo_q[QW-1] ? e_q : e_q - EW'(1);
        shamt  = (er < EW'(1)) ? int'(EW'(1) - er) : 0;
        for (int unsigned i = 0; i < M + 1; i++) begin
            if (int'(i) < shamt) begin
                stk = stk | wv[0];
                wv  = wv >> 1;
            end
        end
        inc    = wv[0] & (stk | wv[1]);
        sum    = {1'b0, wv[M:1]} + {{M{1'b0}}, inc};
        ef     = er;
        frac   = sum[NSIG-1:0];
        excess = '0;
        rq     = '0;
        rflags = '0;
        rovf   = '0;
        if (shamt > 0) begin
            if (sum[M-1:0] == '0) begin
                rq           = {sign_q, {(W-1){1'b0}}};
                rflags[ZERO] = 1'b1;
            end else if (sum[M-1]) begin
                rq             = {sign_q, NEXP'(1), sum[NSIG-1:0]};
                rflags[NORMAL] = 1'b1;
            end else begin
                rq                = {sign_q, {NEXP{1'b0}}, sum[NSIG-1:0]};
                rflags[SUBNORMAL] = 1'b1;
            end
        end else begin
            if (sum[M]) begin
                ef   = er + EW'(1);
                frac = sum[NSIG:1];
            end
            if (ef > EW'(EMAX)) begin
                excess           = ef - EW'(EMAX);
                rq               = {sign_q, {NEXP{1'b1}}, {NSIG{1'b0}}};
                rflags[INFINITY] = 1'b1;
                rovf             = (excess > EW'(OVMAX)) ? '1 : excess[OVW-1:0];
            end else begin
                rq             = {sign_q, ef[NEXP-1:0], frac};
                rflags[NORMAL] = 1'b1;
            end
        end
        rflags[SNAN] = 1'b0;
    end

    logic            ge;
    logic [RW-1:0]   diff;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        e_d     = e_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        flags_d = flags_q;
        ovf_d   = ovf_q;
        ge      = (rem_q >= {1'b0, mb_q});
        diff    = ge ? rem_q - {1'b0, mb_q} : rem_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = NORM;
                end
            end
            NORM: begin
                ovf_d   = '0;
                flags_d = '0;
                if (nan_a || nan_b || (za && zb) || (ia && ib)) begin
                    q_d           = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
                    flags_d[QNAN] = 1'b1;
                    state_d       = DONE;
                end else if (ia || zb) begin
                    q_d               = {s_res, {NEXP{1'b1}}, {NSIG{1'b0}}};
                    flags_d[INFINITY] = 1'b1;
                    state_d           = DONE;
                end else if (za || ib) begin
                    q_d           = {s_res, {(W-1){1'b0}}};
                    flags_d[ZERO] = 1'b1;
                    state_d       = DONE;
                end else begin
                    // Integer quotient bit is resolved here so the remaining bits fit the DIV window
                    mb_d    = mb;
                    rem_d   = {rem0, 1'b0};
                    quo_d   = {{(QW-1){1'b0}}, ge0};
                    e_d     = e_norm;
                    sign_d  = s_res;
                    cnt_d   = CW'(NSIG + 1);
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = {diff[RW-2:0], 1'b0};
                quo_d = {quo_q[QW-2:0], ge};
                if (cnt_q == '0) begin
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ROUND: begin
                q_d     = rq;
                flags_d = rflags;
                ovf_d   = rovf;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mb_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            e_q     <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            q_q     <= '0;
            flags_q <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            e_q     <= e_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            flags_q <= flags_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign q            = q_q;
    assign qFlags       = flags_q;
    assign exp_overflow = ovf_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed plan cases, random operands against an
// exact rational reference model, backpressure and mid-operation reset.
module tb_fp_div_seq;
    localparam int NSIG = 5;
    localparam int BIAS = 1;
    localparam int EMAX = 2;
    localparam logic [5:0] F_NORM = 6'b000001;
    localparam logic [5:0] F_SUB  = 6'b000010;
    localparam logic [5:0] F_ZERO = 6'b000100;
    localparam logic [5:0] F_INF  = 6'b001000;
    localparam logic [5:0] F_QNAN = 6'b010000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       in_ready, out_valid;
    logic [7:0] q;
    logic [5:0] qFlags;
    logic [2:0] exp_overflow;

    int checks = 0;
    int failures = 0;

    fp_div_seq #(.NEXP(2), .NSIG(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .qFlags(qFlags), .exp_overflow(exp_overflow)
    );

    always #5 clk = ~clk;

    // Exact reference: quotient as a rational times a power of two, rounded RNE in integers
    function automatic void ref_div(input logic [7:0] x, input logic [7:0] y,
                                    output logic [7:0] rq, output logic [5:0] rf,
                                    output logic [2:0] ro, output bit spec);
        logic   s;
        bit     xz, yz, xi, yi, xn, yn;
        longint num, den, n2, d2, iq, rm;
        int     p, eu, k, biased;
        s  = x[7] ^ y[7];
        rq = '0; rf = '0; ro = '0; spec = 1'b1;
        xz = (x[6:0] == 7'd0);
        yz = (y[6:0] == 7'd0);
        xi = (x[6:5] == 2'b11) && (x[4:0] == 5'd0);
        yi = (y[6:5] == 2'b11) && (y[4:0] == 5'd0);
        xn = (x[6:5] == 2'b11) && (x[4:0] != 5'd0);
        yn = (y[6:5] == 2'b11) && (y[4:0] != 5'd0);
        if (xn || yn || (xz && yz) || (xi && yi)) begin
            rq = 8'h70; rf = F_QNAN;
        end else if (xi || yz) begin
            rq = {s, 7'b1100000}; rf = F_INF;
        end else if (xz || yi) begin
            rq = {s, 7'b0}; rf = F_ZERO;
        end else begin
            spec = 1'b0;
            num = (x[6:5] == 2'b00) ? longint'(x[4:0]) : longint'(x[4:0]) + 32;
            den = (y[6:5] == 2'b00) ? longint'(y[4:0]) : longint'(y[4:0]) + 32;
            p = ((x[6:5] == 2'b00) ? 1 : int'(x[6:5])) - ((y[6:5] == 2'b00) ? 1 : int'(y[6:5]));
            while (num < den) begin num = num * 2; p--; end
            while (num >= 2 * den) begin den = den * 2; p++; end
            eu = (p < 1 - BIAS) ? 1 - BIAS : p;
            k  = p + NSIG - eu;
            n2 = num; d2 = den;
            if (k >= 0) n2 = num <<< k;
            else d2 = den <<< (-k);
            iq = n2 / d2;
            rm = n2 % d2;
            if (2 * rm > d2 || (2 * rm == d2 && iq[0])) iq++;
            if (iq >= 64) begin iq = iq / 2; eu++; end
            biased = (iq >= 32) ? eu + BIAS : 0;
            if (biased > EMAX) begin
                rq = {s, 7'b1100000}; rf = F_INF;
                ro = (biased - EMAX > 7) ? 3'd7 : 3'(biased - EMAX);
            end else if (iq == 0) begin
                rq = {s, 7'b0}; rf = F_ZERO;
            end else if (biased == 0) begin
                rq = {s, 2'b00, 5'(iq)}; rf = F_SUB;
            end else begin
                rq = {s, 2'(biased), 5'(iq)}; rf = F_NORM;
            end
        end
    endfunction

    // Drives one operation; lat counts edges from the capture edge (inclusive) to out_valid
    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input bit rel,
                         output logic [7:0] rq, output logic [5:0] rf, output logic [2:0] ro,
                         output int lat, output bit tmo);
        @(negedge clk);
        a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tmo = !out_valid;
        rq = q; rf = qFlags; ro = exp_overflow;
        if (rel && !tmo) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
        if (qFlags !== 6'h00) begin failures++; $display("FAIL reset_flags got=%b exp=000000", qFlags); end
        if (exp_overflow !== 3'd0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", exp_overflow); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] ta [7] = '{8'h43, 8'h20, 8'h5F, 8'h20, 8'h00, 8'h68, 8'hA0};
        logic [7:0] tb [7] = '{8'h41, 8'h40, 8'h10, 8'h00, 8'h00, 8'h20, 8'h20};
        logic [7:0] tq [7] = '{8'h22, 8'h10, 8'h60, 8'h60, 8'h70, 8'h70, 8'hA0};
        logic [5:0] tf [7] = '{F_NORM, F_SUB, F_INF, F_INF, F_QNAN, F_QNAN, F_NORM};
        logic [2:0] to [7] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
        int         tl [7] = '{10, 10, 10, 2, 2, 2, 10};
        logic [7:0] rq;
        logic [5:0] rf;
        logic [2:0] ro;
        int         lat;
        bit         tmo;
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb[i], 1'b1, rq, rf, ro, lat, tmo);
            checks += 5;
            if (tmo) begin failures++; $display("FAIL dir%0d_timeout got=no_out_valid exp=out_valid", i); end
            if (rq !== tq[i]) begin failures++; $display("FAIL dir%0d_q got=%h exp=%h", i, rq, tq[i]); end
            if (rf !== tf[i]) begin failures++; $display("FAIL dir%0d_flags got=%b exp=%b", i, rf, tf[i]); end
            if (ro !== to[i]) begin failures++; $display("FAIL dir%0d_ovf got=%0d exp=%0d", i, ro, to[i]); end
            if (lat != tl[i]) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, tl[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] x, y, rq, eq;
        logic [5:0] rf, ef;
        logic [2:0] ro, eo;
        int         lat;
        bit         tmo, spec;
        for (int i = 0; i < 250; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            ref_div(x, y, eq, ef, eo, spec);
            do_op(x, y, 1'b1, rq, rf, ro, lat, tmo);
            checks += 5;
            if (tmo || lat != (spec ? 2 : 10)) begin
                failures++; $display("FAIL rnd_latency a=%h b=%h got=%0d exp=%0d", x, y, lat, spec ? 2 : 10);
            end
            if (rq !== eq) begin failures++; $display("FAIL rnd_q a=%h b=%h got=%h exp=%h", x, y, rq, eq); end
            if (rf !== ef) begin failures++; $display("FAIL rnd_flags a=%h b=%h got=%b exp=%b", x, y, rf, ef); end
            if (ro !== eo) begin failures++; $display("FAIL rnd_ovf a=%h b=%h got=%0d exp=%0d", x, y, ro, eo); end
            if ($countones(rf) != 1) begin failures++; $display("FAIL rnd_onehot a=%h b=%h got=%b exp=onehot", x, y, rf); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] x, y, rq, eq;
        logic [5:0] rf, ef;
        logic [2:0] ro, eo;
        int         lat;
        bit         tmo, spec;
        for (int i = 0; i < 6; i++) begin
            x = 8'($urandom_range(8'h01, 8'h5F));
            y = 8'($urandom_range(8'h01, 8'h5F));
            ref_div(x, y, eq, ef, eo, spec);
            do_op(x, y, 1'b1, rq, rf, ro, lat, tmo);
            checks += 3;
            if (tmo || rq !== eq) begin failures++; $display("FAIL b2b_q a=%h b=%h got=%h exp=%h", x, y, rq, eq); end
            if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
            if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_out_valid got=%b exp=0", out_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] rq;
        logic [5:0] rf;
        logic [2:0] ro;
        int         lat;
        bit         tmo;
        do_op(8'h43, 8'h41, 1'b0, rq, rf, ro, lat, tmo);
        checks++;
        if (tmo || rq !== 8'h22) begin failures++; $display("FAIL bp_q got=%h exp=22", rq); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'h20; b = 8'h00;
            @(posedge clk); #1;
            checks += 4;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            if (q !== 8'h22) begin failures++; $display("FAIL bp_hold_q cyc=%0d got=%h exp=22", i, q); end
            if (qFlags !== F_NORM) begin failures++; $display("FAIL bp_hold_flags cyc=%0d got=%b exp=%b", i, qFlags, F_NORM); end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ignored_input got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rq;
        logic [5:0] rf;
        logic [2:0] ro;
        int         lat;
        bit         tmo;
        bit         seen;
        @(negedge clk);
        a = 8'h43; b = 8'h41; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        if (q !== 8'h00) begin failures++; $display("FAIL rstmid_q got=%h exp=00", q); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL rstmid_aborted got=out_valid exp=none"); end
        do_op(8'h40, 8'h20, 1'b1, rq, rf, ro, lat, tmo);
        checks += 3;
        if (tmo || rq !== 8'h40) begin failures++; $display("FAIL rstmid_next_q got=%h exp=40", rq); end
        if (rf !== F_NORM) begin failures++; $display("FAIL rstmid_next_flags got=%b exp=%b", rf, F_NORM); end
        if (lat != 10) begin failures++; $display("FAIL rstmid_next_latency got=%0d exp=10", lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
